// File: rtl/turf_fragment_reasm_if.sv
`default_nettype none
// ============================================================================
// Module   : turf_fragment_reasm_if
// Brief    : Stream bundle for the TURF fragment reassembler (header, payload,
//            control and data channels).
// Revision : 1.0 - initial release
// ============================================================================
interface turf_fragment_reasm_if;
    logic [63:0] s_hdr_tdata;
    logic        s_hdr_tvalid;
    logic        s_hdr_tready;
    logic [15:0] s_hdr_tuser;

    logic [63:0] s_payload_tdata;
    logic [7:0]  s_payload_tkeep;
    logic        s_payload_tvalid;
    logic        s_payload_tready;
    logic        s_payload_tlast;

    logic [31:0] m_ctrl_tdata;
    logic        m_ctrl_tvalid;
    logic        m_ctrl_tready;

    logic [63:0] m_data_tdata;
    logic [7:0]  m_data_tkeep;
    logic        m_data_tvalid;
    logic        m_data_tready;
    logic        m_data_tlast;
    logic        m_data_tuser;

    // Reassembler side: sinks s_* streams, sources m_* streams.
    modport slave (
        input  s_hdr_tdata, s_hdr_tvalid, s_hdr_tuser,
        output s_hdr_tready,
        input  s_payload_tdata, s_payload_tkeep, s_payload_tvalid, s_payload_tlast,
        output s_payload_tready,
        output m_ctrl_tdata, m_ctrl_tvalid,
        input  m_ctrl_tready,
        output m_data_tdata, m_data_tkeep, m_data_tvalid, m_data_tlast, m_data_tuser,
        input  m_data_tready
    );

    modport master (
        output s_hdr_tdata, s_hdr_tvalid, s_hdr_tuser,
        input  s_hdr_tready,
        output s_payload_tdata, s_payload_tkeep, s_payload_tvalid, s_payload_tlast,
        input  s_payload_tready,
        input  m_ctrl_tdata, m_ctrl_tvalid,
        output m_ctrl_tready,
        input  m_data_tdata, m_data_tkeep, m_data_tvalid, m_data_tlast, m_data_tuser,
        output m_data_tready
    );
endinterface
`default_nettype wire

// File: rtl/turf_fragment_reasm.sv
`default_nettype none
// ============================================================================
// Module   : turf_fragment_reasm
// Brief    : Validates TURF UDP fragment tags and rejoins fragment payloads
//            into one event stream plus an {address,length} control word.
// Revision : 1.0 - initial release
// ============================================================================
module turf_fragment_reasm #(
    parameter logic [15:0] CONSTANT_0 = 16'hDA7A,
    parameter logic [5:0]  CONSTANT_1 = 6'h00,
    parameter int unsigned ERR_BITS   = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    turf_fragment_reasm_if.slave bus,
    output logic                err_o,
    output logic [ERR_BITS-1:0] err_count_o
);

    typedef enum logic [2:0] {
        ST_HDR    = 3'd0,
        ST_TAG    = 3'd1,
        ST_CTRL   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DROP   = 3'd4,
        ST_ABORT  = 3'd5
    } state_t;

    localparam logic [ERR_BITS-1:0] c_err_one = {{(ERR_BITS-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_event;
    logic [9:0]          r_expected;
    logic [11:0]         r_addr;
    logic [19:0]         r_len;
    logic [19:0]         r_remaining;
    logic                r_abort_to_hdr;
    logic                r_err;
    logic [ERR_BITS-1:0] r_err_count;

    logic [9:0]  w_tag_frag;
    logic [11:0] w_tag_addr;
    logic [19:0] w_tag_len;
    logic        w_tag_ok;
    logic        w_evt_last;
    logic        w_cap;
    logic        w_exp_inc;
    logic        w_beat;
    logic        w_clear;
    logic        w_err;
    logic        w_unused_hdr;

    assign w_tag_frag = bus.s_payload_tdata[41:32];
    assign w_tag_addr = bus.s_payload_tdata[31:20];
    assign w_tag_len  = bus.s_payload_tdata[19:0];
    assign w_evt_last = (r_remaining <= 20'd8);

    assign w_tag_ok = (bus.s_payload_tdata[63:48] == CONSTANT_0) &&
                      (bus.s_payload_tdata[47:42] == CONSTANT_1) &&
                      !bus.s_payload_tlast &&
                      ((!r_in_event && (w_tag_frag == 10'd0)) ||
                       (r_in_event && (w_tag_frag == r_expected) &&
                        (w_tag_addr == r_addr) && (w_tag_len == r_len)));

    // Header contents carry no information the reassembler acts on.
    assign w_unused_hdr = ^{bus.s_hdr_tdata, bus.s_hdr_tuser};

    assign bus.m_ctrl_tdata = {r_addr, r_len};
    assign err_o            = r_err;
    assign err_count_o      = r_err_count;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_cap                = 1'b0;
        w_exp_inc            = 1'b0;
        w_beat               = 1'b0;
        w_clear              = 1'b0;
        w_err                = 1'b0;
        bus.s_hdr_tready     = 1'b0;
        bus.s_payload_tready = 1'b0;
        bus.m_ctrl_tvalid    = 1'b0;
        bus.m_data_tdata     = '0;
        bus.m_data_tkeep     = '0;
        bus.m_data_tvalid    = 1'b0;
        bus.m_data_tlast     = 1'b0;
        bus.m_data_tuser     = 1'b0;
        case (r_state)
            ST_HDR: begin
                bus.s_hdr_tready = 1'b1;
                if (bus.s_hdr_tvalid) w_state_nxt = ST_TAG;
            end
            ST_TAG: begin
                bus.s_payload_tready = 1'b1;
                if (bus.s_payload_tvalid) begin
                    if (w_tag_ok) begin
                        if (w_tag_frag == 10'd0) begin
                            w_cap       = 1'b1;
                            w_state_nxt = ST_CTRL;
                        end else begin
                            // Continuation accepted: the next fragment number is due.
                            w_exp_inc   = 1'b1;
                            w_state_nxt = ST_STREAM;
                        end
                    end else begin
                        w_err = 1'b1;
                        if (r_in_event)                w_state_nxt = ST_ABORT;
                        else if (bus.s_payload_tlast)  w_state_nxt = ST_HDR;
                        else                           w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_CTRL: begin
                bus.m_ctrl_tvalid = 1'b1;
                if (bus.m_ctrl_tready) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                bus.m_data_tvalid    = bus.s_payload_tvalid;
                bus.s_payload_tready = bus.m_data_tready;
                bus.m_data_tdata     = bus.s_payload_tdata;
                bus.m_data_tkeep     = bus.s_payload_tkeep;
                bus.m_data_tlast     = w_evt_last;
                if (bus.s_payload_tvalid && bus.m_data_tready) begin
                    w_beat = 1'b1;
                    if (w_evt_last) begin
                        w_clear = 1'b1;
                        if (bus.s_payload_tlast) begin
                            w_state_nxt = ST_HDR;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_DROP;
                        end
                    end else if (bus.s_payload_tlast) begin
                        w_state_nxt = ST_HDR;
                    end
                end
            end
            ST_DROP: begin
                bus.s_payload_tready = 1'b1;
                if (bus.s_payload_tvalid && bus.s_payload_tlast) w_state_nxt = ST_HDR;
            end
            ST_ABORT: begin
                bus.m_data_tvalid = 1'b1;
                bus.m_data_tlast  = 1'b1;
                bus.m_data_tuser  = 1'b1;
                if (bus.m_data_tready) begin
                    w_clear     = 1'b1;
                    w_state_nxt = r_abort_to_hdr ? ST_HDR : ST_DROP;
                end
            end
            default: w_state_nxt = ST_HDR;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_in_event     <= 1'b0;
            r_expected     <= '0;
            r_addr         <= '0;
            r_len          <= '0;
            r_remaining    <= '0;
            r_abort_to_hdr <= 1'b0;
            r_err          <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_err <= w_err;
            if (w_err && (r_err_count != '1)) r_err_count <= r_err_count + c_err_one;
            if ((r_state == ST_TAG) && bus.s_payload_tvalid) r_abort_to_hdr <= bus.s_payload_tlast;
            if (w_cap) begin
                r_addr      <= w_tag_addr;
                r_len       <= w_tag_len;
                r_remaining <= w_tag_len;
                r_in_event  <= 1'b1;
                r_expected  <= 10'd1;
            end else begin
                if (w_exp_inc) r_expected <= r_expected + 10'd1;
                if (w_beat)    r_remaining <= w_evt_last ? 20'd0 : (r_remaining - 20'd8);
                if (w_clear) begin
                    r_in_event <= 1'b0;
                    r_expected <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
